// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int DEFAULT_ADDR_W  = 6;
    localparam int DEFAULT_INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Unconditional jumps are always taken; conditional ones follow the flag.
    function automatic logic br_taken(input logic valid, input logic cond, input logic flag);
        return valid & (~cond | flag);
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Capture register holding the fetched word and its address for decode.
// Latency: load/flush take effect on the next CLK edge.
// Backpressure: none of its own; the sequencer only loads when the register is free.
//
// Ports: CLK/RST (async active-high), load + load_data/load_pc capture a word,
//        flush clears it, instr_data/instr_pc present the held word.
module fetch_hold_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_data <= '0;
            instr_pc   <= '0;
        end else if (flush) begin
            instr_data <= '0;
            instr_pc   <= '0;
        end else if (load) begin
            instr_data <= load_data;
            instr_pc   <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues imem req/ack reads, holds the word for decode.
// Latency: instr_valid one cycle after imem_ack; best case one instruction every two cycles.
// Backpressure: word is held (no new req) until instr_valid & instr_ready; a req is never retracted.
//
// Ports: CLK/RST (async active-high); imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        instr_valid/instr_data/instr_pc/instr_ready decode side; br_valid/br_cond/br_flag/
//        br_target resolved jumps; halt (sticky) / halted.
// Optional: define FETCH_PERF_EN to add perf_fetch / perf_squash saturating counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int INSTR_W    = DEFAULT_INSTR_W,
    parameter int RESET_ADDR = 0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               br_valid,
    input  logic               br_cond,
    input  logic               br_flag,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_squash
`endif
);

    localparam logic [ADDR_W-1:0] RESET_PC = RESET_ADDR[ADDR_W-1:0];

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              squash_q, squash_d;
    // Address of the outstanding request while pc already points at a jump target.
    logic [ADDR_W-1:0] squash_addr_q, squash_addr_d;
    logic              halt_seen_q;
    logic              taken;
    logic              halt_eff;
    logic              hold_load;
    logic              hold_flush;

    assign taken    = br_taken(br_valid, br_cond, br_flag);
    assign halt_eff = halt | halt_seen_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            squash_q      <= 1'b0;
            squash_addr_q <= '0;
            halt_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            squash_addr_q <= squash_addr_d;
            halt_seen_q   <= halt_eff;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_d      = squash_q;
        squash_addr_d = squash_addr_q;
        hold_load     = 1'b0;
        hold_flush    = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = '0;
        instr_valid   = 1'b0;
        halted        = 1'b0;

        case (state_q)
            IDLE: begin
                if (taken) pc_d = br_target;
                state_d = halt_eff ? HALTED : FETCH;
            end

            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = squash_q ? squash_addr_q : pc_q;
                if (imem_ack) begin
                    squash_d = 1'b0;
                    if (taken || squash_q || halt_eff) begin
                        // Returned word is stale or unwanted: drop it and refetch at pc.
                        if (taken) pc_d = br_target;
                        state_d = halt_eff ? HALTED : FETCH;
                    end else begin
                        hold_load = 1'b1;
                        pc_d      = pc_q + 1'b1;
                        state_d   = HOLD;
                    end
                end else if (taken) begin
                    // Request must stay up at its old address until the ack arrives.
                    pc_d          = br_target;
                    squash_d      = 1'b1;
                    squash_addr_d = imem_addr;
                end
            end

            HOLD: begin
                instr_valid = 1'b1;
                if (taken || halt_eff) begin
                    if (taken) pc_d = br_target;
                    hold_flush = 1'b1;
                    state_d    = halt_eff ? HALTED : FETCH;
                end else if (instr_ready) begin
                    state_d = FETCH;
                end
            end

            HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fetch_hold_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_hold (
        .CLK        (CLK),
        .RST        (RST),
        .load       (hold_load),
        .flush      (hold_flush),
        .load_data  (imem_rdata),
        .load_pc    (imem_addr),
        .instr_data (instr_data),
        .instr_pc   (instr_pc)
    );

`ifdef FETCH_PERF_EN
    logic word_xfer;
    logic word_drop;

    assign word_xfer = instr_valid & instr_ready & ~hold_flush;
    assign word_drop = hold_flush | (imem_req & imem_ack & ~hold_load);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetch  <= '0;
            perf_squash <= '0;
        end else begin
            if (word_xfer && perf_fetch != 16'hFFFF)
                perf_fetch <= perf_fetch + 16'd1;
            if (word_drop && perf_squash != 16'hFFFF)
                perf_squash <= perf_squash + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against an event-level model of fetch, hold, jump and halt rules.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_fetch_sequencer;

    logic        CLK;
    logic        RST;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [5:0]  instr_pc;
    logic        instr_ready;
    logic        br_valid;
    logic        br_cond;
    logic        br_flag;
    logic [5:0]  br_target;
    logic        halt;
    logic        halted;

    fetch_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_flag     (br_flag),
        .br_target   (br_target),
        .halt        (halt),
        .halted      (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [64];

    // Model: what the sequencer is doing, expressed as plain facts about the fetch stream.
    bit          m_idle;
    bit          m_fetching;
    bit          m_have;
    bit          m_halted;
    bit          m_discard;
    bit          m_halt_sticky;
    logic [5:0]  m_pc;
    logic [5:0]  m_req_addr;
    logic [15:0] m_word;
    logic [5:0]  m_word_pc;
    int          n_xfer;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_idle = 1; m_fetching = 0; m_have = 0; m_halted = 0;
        m_discard = 0; m_halt_sticky = 0; m_pc = 6'd0; m_req_addr = 6'd0;
        m_word = 16'd0; m_word_pc = 6'd0;
    endtask

    task automatic compare();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching});
        chk("imem_addr", {26'd0, imem_addr}, m_fetching ? {26'd0, m_req_addr} : 32'd0);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        if (m_have) begin
            chk("instr_data", {16'd0, instr_data}, {16'd0, m_word});
            chk("instr_pc", {26'd0, instr_pc}, {26'd0, m_word_pc});
        end
    endtask

    // One clock cycle: check current outputs, apply inputs, advance model, move to next sample point.
    task automatic tick(input bit a, input bit rdy, input bit bv, input bit bc, input bit bf,
                        input logic [5:0] tgt, input bit h);
        bit ack_eff;
        bit taken;
        bit drop;
        compare();
        ack_eff     = a && m_fetching;
        imem_ack    = ack_eff;
        imem_rdata  = ack_eff ? mem[m_req_addr] : 16'hDEAD;
        instr_ready = rdy;
        br_valid    = bv;
        br_cond     = bc;
        br_flag     = bf;
        br_target   = tgt;
        halt        = h;
        taken       = bv && (!bc || bf);
        if (h) m_halt_sticky = 1;

        if (m_halted) begin
        end else if (m_idle) begin
            m_idle = 0;
            if (taken) m_pc = tgt;
            if (m_halt_sticky) m_halted = 1;
            else begin m_fetching = 1; m_req_addr = m_pc; end
        end else if (m_fetching) begin
            if (ack_eff) begin
                drop = taken || m_discard || m_halt_sticky;
                if (taken) m_pc = tgt;
                m_discard = 0;
                if (!drop) begin
                    m_have = 1; m_word = mem[m_req_addr]; m_word_pc = m_req_addr;
                    m_pc = 6'(m_req_addr + 6'd1);
                    m_fetching = 0;
                end else if (m_halt_sticky) begin
                    m_halted = 1; m_fetching = 0;
                end else begin
                    m_req_addr = m_pc;
                end
            end else if (taken) begin
                m_pc = tgt;
                m_discard = 1;
            end
        end else if (m_have) begin
            if (taken || m_halt_sticky) begin
                m_have = 0;
                if (taken) m_pc = tgt;
                if (m_halt_sticky) m_halted = 1;
                else begin m_fetching = 1; m_req_addr = m_pc; end
            end else if (rdy) begin
                m_have = 0; n_xfer++;
                m_fetching = 1; m_req_addr = m_pc;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        imem_ack = 0; imem_rdata = 16'd0; instr_ready = 0;
        br_valid = 0; br_cond = 0; br_flag = 0; br_target = 6'd0; halt = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        n_xfer = 0;
        RST = 1'b1;
        idle_inputs();
        m_reset();
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", {26'd0, imem_addr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_data", {16'd0, instr_data}, 32'd0);
        RST = 1'b0;

        // Zero-wait memory: addresses 0..3 in order, valid one cycle after each ack
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {26'd0, imem_addr}, 32'd0);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_pc", {26'd0, instr_pc}, 32'd0);
        chk("first_data", {16'd0, instr_data}, {16'd0, mem[0]});
        tick(0, 1, 0, 0, 0, 6'd0, 0);
        for (int i = 1; i < 4; i++) begin
            chk("seq_addr", {26'd0, imem_addr}, i);
            tick(1, 0, 0, 0, 0, 6'd0, 0);
            chk("seq_pc", {26'd0, instr_pc}, i);
            tick(0, 1, 0, 0, 0, 6'd0, 0);
        end

        // Ack delayed three cycles: request and address held steady
        for (int k = 0; k < 3; k++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", {26'd0, imem_addr}, 32'd4);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick(0, 1, 0, 0, 0, 6'd0, 0);
        end
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("late_pc", {26'd0, instr_pc}, 32'd4);
        tick(0, 1, 0, 0, 0, 6'd0, 0);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("hold5_pc", {26'd0, instr_pc}, 32'd5);

        // Unconditional jump in HOLD with ready: word dropped, fetch at 20
        tick(0, 1, 1, 0, 0, 6'd20, 0);
        chk("jmp_valid", {31'd0, instr_valid}, 32'd0);
        chk("jmp_addr", {26'd0, imem_addr}, 32'd20);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        // Conditional, flag clear: no effect
        tick(0, 0, 1, 1, 0, 6'd40, 0);
        chk("nt_pc", {26'd0, instr_pc}, 32'd20);
        tick(0, 1, 0, 0, 0, 6'd0, 0);
        chk("nt_addr", {26'd0, imem_addr}, 32'd21);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        // Conditional, flag set: fetch at 9
        tick(0, 0, 1, 1, 1, 6'd9, 0);
        chk("ct_addr", {26'd0, imem_addr}, 32'd9);

        // Jump while the request is pending: old request completes, then target 63, then wrap to 0
        tick(0, 0, 1, 0, 0, 6'd63, 0);
        chk("pend_addr", {26'd0, imem_addr}, 32'd9);
        tick(0, 0, 0, 0, 0, 6'd0, 0);
        chk("pend_addr2", {26'd0, imem_addr}, 32'd9);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("squash_valid", {31'd0, instr_valid}, 32'd0);
        chk("squash_addr", {26'd0, imem_addr}, 32'd63);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("pc63", {26'd0, instr_pc}, 32'd63);
        tick(0, 1, 0, 0, 0, 6'd0, 0);
        chk("wrap_addr", {26'd0, imem_addr}, 32'd0);
        chk("xfer_count", n_xfer, 32'd7);

        // Randomized traffic, no halt
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] t;
            t = ($urandom_range(0, 3) == 0) ? m_pc : 6'($urandom_range(0, 63));
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t, 0);
        end

        // Halt while a request is pending
        for (int k = 0; k < 20 && !m_fetching; k++) tick(0, 1, 0, 0, 0, 6'd0, 0);
        chk("halt_setup_req", {31'd0, imem_req}, 32'd1);
        tick(0, 0, 0, 0, 0, 6'd0, 1);
        chk("halt_pend_req", {31'd0, imem_req}, 32'd1);
        chk("halt_pend_halted", {31'd0, halted}, 32'd0);
        tick(0, 0, 0, 0, 0, 6'd0, 0);
        chk("halt_pend_req2", {31'd0, imem_req}, 32'd1);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("halted_set", {31'd0, halted}, 32'd1);
        chk("halted_req", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1, 1, 1, 0, 0, 6'd33, 0);
            chk("halted_stays", {31'd0, halted}, 32'd1);
            chk("halted_noreq", {31'd0, imem_req}, 32'd0);
        end

        // Reset in the middle of a redirected fetch
        RST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        RST = 1'b0;
        m_reset();
        tick(0, 0, 0, 0, 0, 6'd0, 0);
        tick(0, 0, 1, 0, 0, 6'd30, 0);
        chk("pre_rst_addr", {26'd0, imem_addr}, 32'd0);
        #2;
        RST = 1'b1;
        idle_inputs();
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", {26'd0, imem_addr}, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        m_reset();
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", {26'd0, imem_addr}, 32'd0);
        tick(1, 0, 0, 0, 0, 6'd0, 0);
        tick(0, 1, 0, 0, 0, 6'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
